// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the 2-bit-per-cycle serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/two_bit_adder.sv
// Combinational 2-bit ripple slice: the only arithmetic in the serial adder datapath.
module two_bit_adder (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic       i_cin,
  output logic [1:0] o_sum,
  output logic       o_cout
);

  logic [2:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {2'b00, i_cin};
  assign o_sum   = w_total[1:0];
  assign o_cout  = w_total[2];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial adder controller: adds two WIDTH-bit operands two bits per cycle
// through a single two_bit_adder, publishing sum/cout with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [CNT_W:0]   w_shamt;
  logic [1:0]       w_sliceA;
  logic [1:0]       w_sliceB;
  logic [1:0]       w_addSum;
  logic             w_addCout;
  logic             w_lastSlice;
  logic [WIDTH-1:0] w_sliceMask;
  logic [WIDTH-1:0] w_resultNext;

  two_bit_adder u_slice_adder (
    .i_a    (w_sliceA),
    .i_b    (w_sliceB),
    .i_cin  (r_carry),
    .o_sum  (w_addSum),
    .o_cout (w_addCout)
  );

  // Slice k lives at bit offset 2k; the new slice result is merged into the
  // running result so the final edge can publish it without an extra cycle.
  always_comb begin
    w_stateNext  = r_state;
    w_shamt      = {r_cnt, 1'b0};
    w_sliceA     = 2'(r_a >> w_shamt);
    w_sliceB     = 2'(r_b >> w_shamt);
    w_lastSlice  = (r_cnt == CNT_W'(SLICES - 1));
    w_sliceMask  = WIDTH'(2'b11) << w_shamt;
    w_resultNext = (r_result & ~w_sliceMask) | (WIDTH'(w_addSum) << w_shamt);

    case (r_state)
      IDLE:    if (start) w_stateNext = RUN;
      RUN:     if (w_lastSlice) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Operands are captured only in IDLE, so input changes while busy are invisible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_result <= w_resultNext;
          r_carry  <= w_addCout;
          if (w_lastSlice) begin
            r_sum  <= w_resultNext;
            r_cout <= w_addCout;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random additions
// compared against plain-arithmetic expectations and a fixed latency model.
module tb_serial_adder_ctrl;

  localparam int W   = 8;
  localparam int LAT = W / 2 + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;
  int cycle;
  int lastDoneCycle;

  logic [W-1:0] prevSum;
  logic         prevCout;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transaction starting from IDLE; expected result from plain arithmetic.
  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic opCin, input bit disturb, input bit holdStart);
    logic [W:0] total;
    total = {1'b0, opA} + {1'b0, opB} + {{W{1'b0}}, opCin};
    a = opA;
    b = opB;
    cin = opCin;
    start = 1'b1;
    stepCycle();
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_done", done, 0);
    checkOutput("accept_sum_hold", sum, prevSum);
    for (int e = 2; e <= LAT; e++) begin
      start = holdStart | disturb;
      if (disturb) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
      stepCycle();
      if (e < LAT) begin
        checkOutput("run_busy", busy, 1);
        checkOutput("run_done", done, 0);
        checkOutput("run_sum_hold", sum, prevSum);
        checkOutput("run_cout_hold", cout, prevCout);
      end else begin
        checkOutput("done_pulse", done, 1);
        checkOutput("done_busy", busy, 1);
        checkOutput("done_sum", sum, total[W-1:0]);
        checkOutput("done_cout", cout, total[W]);
        if (holdStart && lastDoneCycle >= 0)
          checkOutput("done_period", cycle - lastDoneCycle, LAT + 1);
        lastDoneCycle = cycle;
      end
    end
    if (!holdStart && !disturb) start = 1'b0;
    stepCycle();
    checkOutput("idle_done_low", done, 0);
    checkOutput("idle_busy_low", busy, 0);
    checkOutput("idle_sum_hold", sum, total[W-1:0]);
    checkOutput("idle_cout_hold", cout, total[W]);
    if (disturb) begin
      start = 1'b0;
      stepCycle();
      checkOutput("no_second_busy", busy, 0);
      checkOutput("no_second_done", done, 0);
      checkOutput("no_second_sum", sum, total[W-1:0]);
    end
    prevSum = total[W-1:0];
    prevCout = total[W];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle = 0;
    lastDoneCycle = -1;
    prevSum = '0;
    prevCout = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hC3, 8'h7E, 1'b1, 1'b1, 1'b0);

    // Abort in the second RUN cycle: outputs clear asynchronously, no done follows.
    a = 8'h12;
    b = 8'h34;
    cin = 1'b1;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    reset = 1'b1;
    #2;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_cout", cout, 0);
    stepCycle();
    reset = 1'b0;
    prevSum = '0;
    prevCout = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      stepCycle();
      checkOutput("abort_no_done", done, 0);
      checkOutput("abort_idle", busy, 0);
    end

    lastDoneCycle = -1;
    for (int i = 0; i < 3; i++)
      applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    stepCycle();

    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("hold_sum_idle", sum, 8'h01);
      checkOutput("hold_cout_idle", cout, 0);
    end

    for (int i = 0; i < 10; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
